// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the lfsr_prbs family.
// The optional period counter in lfsr_prbs is enabled by the LFSR_PERIOD_CNT_EN macro.
package lfsr_pkg;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  // Maximal-length tap masks (bit i set = q[i] is a tap), indexed by width.
  function automatic logic [31:0] lfsr_default_taps(input int n);
    logic [31:0] t;
    case (n)
      2:  t = 32'h0000_0003;
      3:  t = 32'h0000_0006;
      4:  t = 32'h0000_000C;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0E08;
      13: t = 32'h0000_1C80;
      14: t = 32'h0000_3802;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_D008;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0007_2000;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR next-state for Fibonacci or Galois topology.
// Shared by the generator and any future PRBS checker.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int N = 8,
  parameter logic [N-1:0] TAPS = N'(8'hB8)
) (
  input  logic [N-1:0] q,
  input  logic         mode,
  output logic [N-1:0] nxt,
  output logic         nxt_zero
);

  logic fb;

  // Fibonacci shifts the tap parity in at the top; Galois folds the exiting bit into the taps.
  always_comb begin
    fb = ^(q & TAPS);
    if (mode == MODE_FIB) begin
      nxt = {fb, q[N-1:1]};
    end else begin
      nxt = {1'b0, q[N-1:1]} ^ ({N{q[0]}} & TAPS);
    end
  end

  assign nxt_zero = (nxt == '0);

endmodule

// File: rtl/lfsr_prbs.sv
// Parametrised PRBS generator: load/step/hold, all-zero lock-up recovery,
// wrap detection against the last loaded (or reset) reference state.
// Define LFSR_PERIOD_CNT_EN to build the step counter that reports the period.
module lfsr_prbs
  import lfsr_pkg::*;
#(
  parameter int N = 8,
  parameter logic [N-1:0] TAPS = N'(8'hB8),
  parameter logic [N-1:0] INIT = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         mode,
  input  logic         load,
  input  logic [N-1:0] seed,
  output logic [N-1:0] q,
  output logic         bit_out,
  output logic         lockup,
  output logic         wrap,
  output logic [N-1:0] period
);

  localparam logic [N-1:0] ONES    = '1;
  localparam logic [N-1:0] RST_VAL = (INIT == '0) ? ONES : INIT;

  logic [N-1:0] nxt;
  logic         nxt_zero;
  logic [N-1:0] committed;
  logic [N-1:0] ref_state;
  logic         step;
  logic         wrap_hit;

  lfsr_next #(.N(N), .TAPS(TAPS)) u_next (
    .q        (q),
    .mode     (mode),
    .nxt      (nxt),
    .nxt_zero (nxt_zero)
  );

  // A zero next state would lock the register forever, so substitute all-ones.
  always_comb begin
    committed = nxt_zero ? ONES : nxt;
    step      = en && !load;
    wrap_hit  = step && (committed == ref_state);
  end

  assign bit_out = q[0];

  // State, reference and one-cycle status pulses; priority reset > load > en > hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q         <= RST_VAL;
      ref_state <= RST_VAL;
      lockup    <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      lockup <= 1'b0;
      wrap   <= 1'b0;
      if (load) begin
        if (seed == '0) begin
          q         <= ONES;
          ref_state <= ONES;
          lockup    <= 1'b1;
        end else begin
          q         <= seed;
          ref_state <= seed;
        end
      end else if (en) begin
        q      <= committed;
        lockup <= nxt_zero;
        wrap   <= wrap_hit;
      end
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [N-1:0] count;
  logic [N-1:0] count_inc;

  // Saturating increment so an unreachable reference never rolls the counter over.
  always_comb begin
    count_inc = (count == ONES) ? count : count + 1'b1;
  end

  // Count steps since the last load/wrap; capture the length when the sequence wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      period <= '0;
    end else if (load) begin
      count <= '0;
    end else if (step) begin
      if (wrap_hit) begin
        period <= count_inc;
        count  <= '0;
      end else begin
        count <= count_inc;
      end
    end
  end
`else
  assign period = '0;
`endif

endmodule

// File: tb/tb_lfsr_prbs.sv
// Self-checking bench for lfsr_prbs: three N=4 instances with different tap
// masks share one stimulus stream and are compared against a behavioural model.
module tb_lfsr_prbs;

  logic       clk;
  logic       reset;
  logic       en;
  logic       mode;
  logic       load;
  logic [3:0] seed;

  logic [3:0] q_o  [3];
  logic       b_o  [3];
  logic       lk_o [3];
  logic       wr_o [3];
  logic [3:0] pe_o [3];

  logic [3:0] tap_t [3];
  logic [3:0] m_q   [3];
  logic [3:0] m_ref [3];
  logic [3:0] m_per [3];
  logic       m_lk  [3];
  logic       m_wr  [3];
  int         m_cnt [3];

  int n_cmp;
  int n_bad;

  lfsr_prbs #(.N(4), .TAPS(4'b1001), .INIT(4'b1111)) dut0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .seed(seed),
    .q(q_o[0]), .bit_out(b_o[0]), .lockup(lk_o[0]), .wrap(wr_o[0]), .period(pe_o[0])
  );
  lfsr_prbs #(.N(4), .TAPS(4'b1100), .INIT(4'b1111)) dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .seed(seed),
    .q(q_o[1]), .bit_out(b_o[1]), .lockup(lk_o[1]), .wrap(wr_o[1]), .period(pe_o[1])
  );
  lfsr_prbs #(.N(4), .TAPS(4'b0000), .INIT(4'b0000)) dut2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .seed(seed),
    .q(q_o[2]), .bit_out(b_o[2]), .lockup(lk_o[2]), .wrap(wr_o[2]), .period(pe_o[2])
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the spec's arithmetic rules, on plain integers.
  function automatic logic [3:0] model_next(input logic [3:0] s, input logic [3:0] t, input logic m);
    int v;
    if (!m) begin
      v = (s >> 1) + 8 * ($countones(s & t) % 2);
    end else begin
      v = s >> 1;
      if (s % 2 == 1) v = v ^ int'(t);
    end
    return 4'(v);
  endfunction

  function automatic logic [3:0] exp_period(input int i);
`ifdef LFSR_PERIOD_CNT_EN
    return m_per[i];
`else
    return 4'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_q[i] = 4'b1111; m_ref[i] = 4'b1111; m_per[i] = 4'd0;
      m_lk[i] = 1'b0; m_wr[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] n;
    for (int i = 0; i < 3; i++) begin
      m_lk[i] = 1'b0;
      m_wr[i] = 1'b0;
      if (load) begin
        if (seed == 4'd0) begin m_q[i] = 4'b1111; m_lk[i] = 1'b1; end
        else m_q[i] = seed;
        m_ref[i] = m_q[i];
        m_cnt[i] = 0;
      end else if (en) begin
        n = model_next(m_q[i], tap_t[i], mode);
        if (n == 4'd0) begin n = 4'b1111; m_lk[i] = 1'b1; end
        m_cnt[i] = (m_cnt[i] + 1 > 15) ? 15 : m_cnt[i] + 1;
        if (n == m_ref[i]) begin
          m_wr[i] = 1'b1; m_per[i] = 4'(m_cnt[i]); m_cnt[i] = 0;
        end
        m_q[i] = n;
      end
    end
  endtask

  // Driver: one active edge with model update, then settle away from the edge.
  task automatic step_clk();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0; seed = 4'd0;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (q_o[i] !== 4'b1111 || lk_o[i] !== 1'b0 || wr_o[i] !== 1'b0 || pe_o[i] !== 4'd0 || b_o[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL reset inst%0d: q=%b lk=%b wr=%b per=%0d bit=%b expected q=1111 lk=0 wr=0 per=0 bit=1",
                 i, q_o[i], lk_o[i], wr_o[i], pe_o[i], b_o[i]);
      end
    end
  endtask

  task automatic test_fib_seq();
    logic [3:0] fib_exp [4];
    fib_exp = '{4'b0111, 4'b1011, 4'b0101, 4'b1010};
    do_reset();
    mode = 1'b0; en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step_clk();
      if (k <= 4) begin
        n_cmp++;
        if (q_o[0] !== fib_exp[k-1]) begin
          n_bad++;
          $display("FAIL fib_seq step%0d: q=%b expected %b", k, q_o[0], fib_exp[k-1]);
        end
      end
      n_cmp++;
      if (wr_o[0] !== (k == 15) || q_o[0] !== m_q[0]) begin
        n_bad++;
        $display("FAIL fib_wrap step%0d: q=%b wr=%b expected q=%b wr=%b", k, q_o[0], wr_o[0], m_q[0], k == 15);
      end
    end
    n_cmp++;
`ifdef LFSR_PERIOD_CNT_EN
    if (pe_o[0] !== 4'd15) begin n_bad++; $display("FAIL fib_period: period=%0d expected 15", pe_o[0]); end
`else
    if (pe_o[0] !== 4'd0) begin n_bad++; $display("FAIL fib_period: period=%0d expected 0", pe_o[0]); end
`endif
    en = 1'b0;
    step_clk();
    n_cmp++;
    if (wr_o[0] !== 1'b0) begin n_bad++; $display("FAIL hold_no_wrap: wr=%b expected 0", wr_o[0]); end
  endtask

  task automatic test_galois_seq();
    logic [3:0] gal_exp [5];
    gal_exp = '{4'b0001, 4'b1100, 4'b0110, 4'b0011, 4'b1101};
    mode = 1'b1; load = 1'b1; seed = 4'b0001; en = 1'b0;
    step_clk();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      if (k <= 4) begin
        n_cmp++;
        if (q_o[1] !== gal_exp[k]) begin
          n_bad++;
          $display("FAIL gal_seq step%0d: q=%b expected %b", k, q_o[1], gal_exp[k]);
        end
      end
      if (k > 0) begin
        n_cmp++;
        if (wr_o[1] !== (k == 15) || pe_o[1] !== exp_period(1)) begin
          n_bad++;
          $display("FAIL gal_wrap step%0d: wr=%b per=%0d expected wr=%b per=%0d", k, wr_o[1], pe_o[1], k == 15, exp_period(1));
        end
      end
      if (k < 15) step_clk();
    end
    en = 1'b0;
  endtask

  task automatic test_seed_zero();
    load = 1'b1; seed = 4'd0; en = 1'b0;
    step_clk();
    load = 1'b0;
    n_cmp++;
    if (q_o[0] !== 4'b1111 || lk_o[0] !== 1'b1 || wr_o[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL seed_zero: q=%b lk=%b wr=%b expected q=1111 lk=1 wr=0", q_o[0], lk_o[0], wr_o[0]);
    end
    step_clk();
    n_cmp++;
    if (lk_o[0] !== 1'b0) begin n_bad++; $display("FAIL seed_zero_pulse: lk=%b expected 0", lk_o[0]); end
  endtask

  task automatic test_load_en();
    logic [3:0] prev;
    logic       en_pat [3];
    en_pat = '{1'b1, 1'b0, 1'b1};
    mode = 1'b0; load = 1'b1; en = 1'b1; seed = 4'b1010;
    step_clk();
    load = 1'b0;
    n_cmp++;
    if (q_o[0] !== 4'b1010) begin n_bad++; $display("FAIL load_priority: q=%b expected 1010", q_o[0]); end
    for (int k = 0; k < 3; k++) begin
      prev = m_q[0];
      en = en_pat[k];
      step_clk();
      n_cmp++;
      if (q_o[0] !== (en_pat[k] ? model_next(prev, 4'b1001, 1'b0) : prev)) begin
        n_bad++;
        $display("FAIL en_toggle k%0d: q=%b expected %b", k, q_o[0], m_q[0]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    mode = 1'b0; en = 1'b1;
    repeat (5) step_clk();
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (q_o[i] !== 4'b1111 || lk_o[i] !== 1'b0 || wr_o[i] !== 1'b0 || pe_o[i] !== 4'd0) begin
        n_bad++;
        $display("FAIL async_reset inst%0d: q=%b lk=%b wr=%b per=%0d expected q=1111 lk=0 wr=0 per=0",
                 i, q_o[i], lk_o[i], wr_o[i], pe_o[i]);
      end
    end
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0; en = 1'b0;
  endtask

  task automatic test_taps_zero();
    logic [3:0] z_exp [4];
    z_exp = '{4'b0111, 4'b0011, 4'b0001, 4'b1111};
    do_reset();
    mode = 1'b0; en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step_clk();
      n_cmp++;
      if (q_o[2] !== z_exp[k % 4] || lk_o[2] !== (k % 4 == 3)) begin
        n_bad++;
        $display("FAIL taps_zero step%0d: q=%b lk=%b expected q=%b lk=%b", k, q_o[2], lk_o[2], z_exp[k % 4], k % 4 == 3);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en   = ($urandom_range(0, 3) != 0);
      mode = ($urandom_range(0, 7) == 0) ? ~mode : mode;
      load = ($urandom_range(0, 19) == 0);
      seed = 4'($urandom_range(0, 15));
      step_clk();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (q_o[i] !== m_q[i] || b_o[i] !== m_q[i][0] || lk_o[i] !== m_lk[i] || wr_o[i] !== m_wr[i] || pe_o[i] !== exp_period(i)) begin
          n_bad++;
          $display("FAIL random inst%0d cyc%0d: q=%b bit=%b lk=%b wr=%b per=%0d expected q=%b lk=%b wr=%b per=%0d",
                   i, c, q_o[i], b_o[i], lk_o[i], wr_o[i], pe_o[i], m_q[i], m_lk[i], m_wr[i], exp_period(i));
        end
      end
    end
    en = 1'b0; load = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tap_t = '{4'b1001, 4'b1100, 4'b0000};
    reset = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; seed = 4'd0;
    model_reset();
    test_reset();
    test_fib_seq();
    test_galois_seq();
    test_seed_zero();
    test_load_en();
    test_async_reset();
    test_taps_zero();
    do_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs.md
Name: lfsr_prbs

Overview:
- Parametrised successor to the team's fixed 4-bit Fibonacci LFSR.
- Generic width N, runtime-selectable Fibonacci/Galois topology, step enable and seed load.
- Recovers automatically from an all-zero lock-up state and flags sequence wrap.
- Used as the PRBS source for BIST pattern generation and link test traffic.

Parameters:
- N, 8: state width in bits; legal range 2..32.
- TAPS, 8'hB8: feedback tap mask, N bits wide; bit i set means q[i] is a tap.
- INIT, all ones: reset state; if INIT is 0, reset loads {N{1'b1}} instead.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance the LFSR by one step this cycle.
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled every step.
- load  in  1  load seed this cycle; has priority over en.
- seed  in  N  value to load when load = 1.
- q  out  N  current LFSR state (registered).
- bit_out  out  1  serial PRBS bit; combinational, equal to q[0].
- lockup  out  1  one-cycle pulse: an all-zero state was replaced by all-ones.
- wrap  out  1  one-cycle pulse: state returned to the reference value.
- period  out  N  last measured sequence length; see Optional Feature.

Behaviour:
- Reset (asynchronous assertion):
  - q = INIT, or all-ones if INIT == 0.
  - ref = q.
  - lockup = 0, wrap = 0, period = 0, internal step count = 0.
- Priority each cycle: reset > load > en > hold.
- Load: q <= seed and ref <= seed.
  - If seed == 0: q and ref both take {N{1'b1}} and lockup pulses on the next cycle.
  - Load clears the step count and never raises wrap.
- Step when en = 1 and load = 0, mode = 0 (Fibonacci):
  - fb = XOR of q[i] over all i with TAPS[i] = 1.
  - q <= {fb, q[N-1:1]}.
- Step when en = 1 and load = 0, mode = 1 (Galois):
  - q <= {1'b0, q[N-1:1]} ^ ({N{q[0]}} & TAPS).
- Lock-up guard: if the computed next state is all-zero (non-primitive TAPS, or TAPS = 0), q <= {N{1'b1}} instead and lockup pulses the following cycle.
- wrap: registered; high for exactly the one cycle after a step whose committed next state equals ref. Holds (en = 0) never assert wrap.
- mode change mid-sequence:
  - Takes effect on the next step; no flush.
  - ref is unchanged, so wrap may never fire until the next load. This is legal.
- latency:
  - q updates one cycle after en or load.
  - bit_out follows q with no extra delay.
  - lockup and wrap appear one cycle after the step or load that caused them.
- Reset asserted mid-sequence: immediate return to the reset state; no pending pulse survives.

Optional Feature:
- Macro: LFSR_PERIOD_CNT_EN.
- Defined:
  - An N-bit step counter increments on each step and saturates at all-ones.
  - On wrap: period <= count + 1 and count <= 0.
  - Load clears count but keeps period.
  - Reset clears both count and period.
- Undefined:
  - period is tied to 0 and no counter logic is generated.
  - All other behaviour is identical.

Decomposition:
- Package lfsr_pkg:
  - localparams MODE_FIB = 1'b0 and MODE_GAL = 1'b1.
  - function lfsr_default_taps(N) returning a maximal-length tap mask for N = 2..32.
- Sub-module lfsr_next: purely combinational next-state.
  - Inputs: q, mode, TAPS parameter.
  - Outputs: nxt and nxt_zero.
  - Instantiated once by lfsr_prbs.
  - Reusable by a future PRBS checker.

Test Plan:
- N = 4, TAPS = 4'b1001, INIT = 4'b1111, mode = 0, en held high:
  - q sequence 1111 -> 0111 -> 1011 -> 0101 -> 1010.
  - wrap pulses 15 steps after reset.
  - With the macro defined, period = 15.
- N = 4, TAPS = 4'b1100, load seed 4'b0001, mode = 1:
  - q sequence 0001 -> 1100 -> 0110 -> 0011 -> 1101.
  - wrap after 15 steps.
- load = 1 with seed = 0:
  - next cycle q = 1111 and lockup = 1 for one cycle.
  - No wrap is raised.
- load = 1 and en = 1 in the same cycle with seed = 4'b1010:
  - q = 1010; no step taken.
  - Then en toggled 1/0/1: q advances only on en-high cycles.
- reset asserted asynchronously between clock edges mid-sequence (en = 1):
  - q = INIT immediately, before the next edge.
  - lockup, wrap and period read 0.
- TAPS = 0, N = 4:
  - First step from 1111 yields 0111, then 0011, 0001, then the all-zero guard forces 1111.
  - lockup pulses once per recovery.
